// File: rtl/game_sprite_mover_pkg.sv
// Shared game configuration: screen geometry, coordinate/velocity widths and
// small arithmetic helpers used by the sprite movers and the game master.
package game_sprite_mover_pkg;

  // Coordinate width shared with the display timing and the game master FSM.
  localparam int unsigned CoordW = 10;
  // Velocity is a small two's complement step, range -4..+3.
  localparam int unsigned VelW = 3;

  localparam int unsigned GameScreenWidth  = 640;
  localparam int unsigned GameScreenHeight = 480;

  typedef logic [CoordW-1:0] coord_t;
  // One extra bit so coordinate + extent never overflows.
  typedef logic [CoordW:0]   coord_ext_t;
  typedef logic [VelW-1:0]   vel_t;

  // What happens to the position register on the coming clock edge.
  typedef enum logic [1:0] {
    MvHold,
    MvLoad,
    MvStep
  } move_e;

  // Position plus sign-extended velocity, wrapping modulo 2^CoordW.
  function automatic coord_t add_vel(coord_t pos, vel_t vel);
    coord_t vel_ext;
    vel_ext = {{(CoordW-VelW){vel[VelW-1]}}, vel};
    return pos + vel_ext;
  endfunction

  // True when lo <= p < lo + len, evaluated without overflow.
  function automatic logic in_span(coord_t lo, coord_t p, int unsigned len);
    coord_ext_t hi;
    hi = {1'b0, lo} + coord_ext_t'(len);
    return (p >= lo) && ({1'b0, p} < hi);
  endfunction

  // True when the extent starting at pos fits entirely inside limit.
  function automatic logic fits(coord_t pos, int unsigned len, int unsigned limit);
    coord_ext_t sum;
    sum = {1'b0, pos} + coord_ext_t'(len);
    return sum <= coord_ext_t'(limit);
  endfunction

endpackage

// File: rtl/game_sprite_mover_strobe.sv
// Free-running movement divider. The strobe is high for exactly one cycle out
// of every 2^STROBE_WIDTH, when the counter reads all-ones.
module game_strobe_gen #(
  parameter int unsigned STROBE_WIDTH = 20
) (
  input  logic clk,
  input  logic reset_n,
  output logic strobe
);

  logic [STROBE_WIDTH-1:0] cnt_q;
  logic [STROBE_WIDTH-1:0] cnt_d;

  // Counter next state: always increments, wraps naturally at all-ones.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared asynchronously so a reset aborts any pending move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe = &cnt_q;

endmodule

// File: rtl/game_sprite_mover.sv
// Sprite position/velocity holder for one game object (target or torpedo).
// The game master writes position and velocity directly; the sprite steps by
// its velocity on each divider strobe while enable_update is high.
module game_sprite_mover #(
  parameter int unsigned SCREEN_WIDTH  = game_sprite_mover_pkg::GameScreenWidth,
  parameter int unsigned SCREEN_HEIGHT = game_sprite_mover_pkg::GameScreenHeight,
  parameter int unsigned SPRITE_WIDTH  = 8,
  parameter int unsigned SPRITE_HEIGHT = 8,
  parameter int unsigned STROBE_WIDTH  = 20
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          write_xy,
  input  logic                          write_dxy,
  input  logic                          enable_update,
  input  game_sprite_mover_pkg::coord_t x_to_write,
  input  game_sprite_mover_pkg::coord_t y_to_write,
  input  game_sprite_mover_pkg::vel_t   dx_to_write,
  input  game_sprite_mover_pkg::vel_t   dy_to_write,
  input  game_sprite_mover_pkg::coord_t pixel_x,
  input  game_sprite_mover_pkg::coord_t pixel_y,
  output game_sprite_mover_pkg::coord_t x,
  output game_sprite_mover_pkg::coord_t y,
  output logic                          within_screen,
  output logic                          pixel_hit
);

  import game_sprite_mover_pkg::*;

  logic   strobe;
  move_e  move;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  vel_t   dx_q, dx_d;
  vel_t   dy_q, dy_d;
  logic   pixel_hit_q, pixel_hit_d;

  game_strobe_gen #(
    .STROBE_WIDTH(STROBE_WIDTH)
  ) u_strobe (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (strobe)
  );

  // Decide the position update; a host write always beats a movement step.
  always_comb begin
    move = MvHold;
    if (write_xy) begin
      move = MvLoad;
    end else if (strobe && enable_update) begin
      move = MvStep;
    end
  end

  // Position next state. Steps use the velocity currently held, so a velocity
  // write in the same cycle only affects later steps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    unique case (move)
      MvLoad: begin
        x_d = x_to_write;
        y_d = y_to_write;
      end
      MvStep: begin
        x_d = add_vel(x_q, dx_q);
        y_d = add_vel(y_q, dy_q);
      end
      default: begin
        x_d = x_q;
        y_d = y_q;
      end
    endcase
  end

  // Velocity next state, loaded independently of the position write.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (write_dxy) begin
      dx_d = dx_to_write;
      dy_d = dy_to_write;
    end
  end

  // Scan coordinate versus current sprite box; registered for one cycle latency.
  always_comb begin
    pixel_hit_d = in_span(x_q, pixel_x, SPRITE_WIDTH) &&
                  in_span(y_q, pixel_y, SPRITE_HEIGHT);
  end

  // State registers: position, velocity and the registered hit flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      pixel_hit_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      pixel_hit_q <= pixel_hit_d;
    end
  end

  // Wrapped-negative coordinates land near 1023 and therefore read off-screen.
  assign within_screen = fits(x_q, SPRITE_WIDTH, SCREEN_WIDTH) &&
                         fits(y_q, SPRITE_HEIGHT, SCREEN_HEIGHT);

  assign x         = x_q;
  assign y         = y_q;
  assign pixel_hit = pixel_hit_q;

endmodule

// File: tb/tb_game_sprite_mover.sv
// Bench for game_sprite_mover with a 16-cycle strobe period.
module tb_game_sprite_mover;

  localparam int StrobePeriod = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_xy = 1'b0;
  logic       write_dxy = 1'b0;
  logic       enable_update = 1'b0;
  logic [9:0] x_to_write = '0;
  logic [9:0] y_to_write = '0;
  logic [2:0] dx_to_write = '0;
  logic [2:0] dy_to_write = '0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [9:0] x;
  logic [9:0] y;
  logic       within_screen;
  logic       pixel_hit;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_x, m_y, m_dx, m_dy, m_cyc, m_hit;
  bit last_strobe;

  game_sprite_mover #(
    .STROBE_WIDTH(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_xy     (write_xy),
    .write_dxy    (write_dxy),
    .enable_update(enable_update),
    .x_to_write   (x_to_write),
    .y_to_write   (y_to_write),
    .dx_to_write  (dx_to_write),
    .dy_to_write  (dy_to_write),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .x            (x),
    .y            (y),
    .within_screen(within_screen),
    .pixel_hit    (pixel_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_ws();
    return ((m_x + 8 <= 640) && (m_y + 8 <= 480)) ? 1 : 0;
  endfunction

  task automatic check_model();
    check("x", int'(x), m_x);
    check("y", int'(y), m_y);
    check("within_screen", int'(within_screen), model_ws());
    check("pixel_hit", int'(pixel_hit), m_hit);
  endtask

  // One clock: model computed from pre-edge state and inputs, compared at +1.
  task automatic cycle();
    int nx, ny, ndx, ndy, nhit;
    bit stb;
    stb  = (m_cyc % StrobePeriod) == StrobePeriod - 1;
    nx   = m_x;
    ny   = m_y;
    if (write_xy) begin
      nx = int'(x_to_write);
      ny = int'(y_to_write);
    end else if (stb && enable_update) begin
      nx = (m_x + m_dx + 1024) % 1024;
      ny = (m_y + m_dy + 1024) % 1024;
    end
    ndx  = write_dxy ? int'($signed(dx_to_write)) : m_dx;
    ndy  = write_dxy ? int'($signed(dy_to_write)) : m_dy;
    nhit = (int'(pixel_x) >= m_x && int'(pixel_x) < m_x + 8 &&
            int'(pixel_y) >= m_y && int'(pixel_y) < m_y + 8) ? 1 : 0;
    @(posedge clk);
    #1;
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_hit = nhit;
    m_cyc++;
    last_strobe = stb;
    check_model();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    write_xy = 0; write_dxy = 0; enable_update = 0;
    #1;
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_hit = 0; m_cyc = 0;
    check("reset x", int'(x), 0);
    check("reset y", int'(y), 0);
    check("reset within_screen", int'(within_screen), 1);
    check("reset pixel_hit", int'(pixel_hit), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load(input int lx, input int ly, input int ldx, input int ldy,
                      input bit en);
    write_xy = 1; write_dxy = 1; enable_update = en;
    x_to_write = 10'(lx); y_to_write = 10'(ly);
    dx_to_write = 3'(ldx); dy_to_write = 3'(ldy);
    cycle();
    write_xy = 0; write_dxy = 0;
  endtask

  // Idle cycles until just after the next strobe edge (bounded by one period).
  task automatic run_to_strobe();
    for (int i = 0; i < StrobePeriod; i++) begin
      cycle();
      if (last_strobe) return;
    end
    check("strobe seen within period", 0, 1);
  endtask

  typedef struct {
    int x; int y; int px; int py; int ws; int hit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{x: 0,    y: 0,   px: 0,    py: 0,   ws: 1, hit: 1};
    vecs[1] = '{x: 632,  y: 472, px: 639,  py: 479, ws: 1, hit: 1};
    vecs[2] = '{x: 633,  y: 0,   px: 633,  py: 0,   ws: 0, hit: 1};
    vecs[3] = '{x: 0,    y: 473, px: 5,    py: 480, ws: 0, hit: 1};
    vecs[4] = '{x: 100,  y: 100, px: 108,  py: 100, ws: 1, hit: 0};
    vecs[5] = '{x: 100,  y: 100, px: 99,   py: 107, ws: 1, hit: 0};
    vecs[6] = '{x: 1020, y: 5,   px: 3,    py: 5,   ws: 0, hit: 0};
    vecs[7] = '{x: 1020, y: 5,   px: 1023, py: 12,  ws: 0, hit: 1};

    do_reset();

    // Idle after reset: nothing moves, box on screen, no hit at scan (500,400).
    pixel_x = 10'd500; pixel_y = 10'd400;
    for (int i = 0; i < 20; i++) cycle();
    check("idle x", int'(x), 0);
    check("idle within_screen", int'(within_screen), 1);

    // Table: static geometry of within_screen and pixel_hit.
    foreach (vecs[i]) begin
      pixel_x = 10'(vecs[i].px); pixel_y = 10'(vecs[i].py);
      load(vecs[i].x, vecs[i].y, 0, 0, 0);
      cycle();
      check($sformatf("vec%0d within_screen", i), int'(within_screen), vecs[i].ws);
      check($sformatf("vec%0d pixel_hit", i), int'(pixel_hit), vecs[i].hit);
    end

    // Steady motion (+2,-1) from (100,200).
    do_reset();
    pixel_x = 10'd0; pixel_y = 10'd0;
    load(100, 200, 2, -1, 1);
    for (int k = 1; k <= 3; k++) begin
      run_to_strobe();
      check($sformatf("motion x step%0d", k), int'(x), 100 + 2 * k);
      check($sformatf("motion y step%0d", k), int'(y), 200 - k);
    end

    // Right screen edge.
    load(632, 0, 1, 0, 0);
    check("edge ws at 632", int'(within_screen), 1);
    enable_update = 1;
    run_to_strobe();
    check("edge x 633", int'(x), 633);
    check("edge ws at 633", int'(within_screen), 0);

    // Wrap below zero.
    load(0, 0, -1, 0, 1);
    run_to_strobe();
    check("wrap x", int'(x), 1023);
    check("wrap ws", int'(within_screen), 0);

    // Position write coinciding with a strobe wins; next strobe steps by +3.
    load(0, 0, 3, 0, 1);
    while ((m_cyc % StrobePeriod) != StrobePeriod - 1) cycle();
    write_xy = 1; x_to_write = 10'd50; y_to_write = 10'd50;
    cycle();
    write_xy = 0;
    check("write wins x", int'(x), 50);
    run_to_strobe();
    check("after write x", int'(x), 53);

    // Pixel sweep across a box at (10,10).
    load(10, 10, 0, 0, 0);
    pixel_y = 10'd10;
    for (int px = 9; px <= 18; px++) begin
      pixel_x = 10'(px);
      cycle();
      check($sformatf("sweep hit px=%0d", px), int'(pixel_hit),
            (px >= 10 && px <= 17) ? 1 : 0);
    end

    // Randomized traffic against the model, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        for (int j = 0; j < StrobePeriod - 1; j++) cycle();
        enable_update = 1;
        check("no strobe before period", int'(x), 0);
      end
      write_xy      = ($urandom_range(0, 9) == 0);
      write_dxy     = ($urandom_range(0, 5) == 0);
      enable_update = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        x_to_write = 10'($urandom_range(0, 1023));
      else
        x_to_write = 10'($urandom_range(620, 640));
      y_to_write  = 10'($urandom_range(460, 480));
      dx_to_write = 3'($urandom);
      dy_to_write = 3'($urandom);
      pixel_x     = 10'((m_x + $urandom_range(0, 10) + 1023) % 1024);
      pixel_y     = 10'((m_y + $urandom_range(0, 10) + 1023) % 1024);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
    $fatal(1);
  end

endmodule
